// File: rtl/ram_march_bist.sv
// March-test BIST initiator for a single-port RAM: write background, read/verify/invert
// ascending, then read/verify descending; reports pass or the first failing location.
module ram_march_bist #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              fail_phase,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ALAST = '1;

  typedef enum logic [2:0] {
    IDLE, PA_W, PB_R, PB_WAIT, PB_W, PC_R, PC_WAIT, END
  } state_t;

  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic clr, rec_pass, rec_fail, rec_phase;
  logic busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      wcnt <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      wcnt <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n = addr;
    wcnt_n = wcnt;
    clr = 1'b0;
    rec_pass = 1'b0;
    rec_fail = 1'b0;
    rec_phase = 1'b0;
    case (state)
      IDLE, END: begin
        // END behaves like IDLE except that results are held for the requester
        if (start) begin
          state_n = PA_W;
          addr_n = '0;
          clr = 1'b1;
        end
      end
      PA_W: begin
        if (addr == ALAST) begin
          state_n = PB_R;
          addr_n = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      PB_R: begin
        state_n = PB_WAIT;
        wcnt_n = '0;
      end
      PB_WAIT: begin
        if (wcnt == WLAST) begin
          if (ram_dout != PATTERN) begin
            state_n = END;
            rec_fail = 1'b1;
          end else begin
            state_n = PB_W;
          end
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      PB_W: begin
        // phase C starts at the address phase B just finished, so no wrap
        state_n = PC_R;
        if (addr != ALAST) begin
          state_n = PB_R;
          addr_n = addr + 1'b1;
        end
      end
      PC_R: begin
        state_n = PC_WAIT;
        wcnt_n = '0;
      end
      PC_WAIT: begin
        if (wcnt == WLAST) begin
          if (ram_dout != ~PATTERN) begin
            state_n = END;
            rec_fail = 1'b1;
            rec_phase = 1'b1;
          end else if (addr == '0) begin
            state_n = END;
            rec_pass = 1'b1;
          end else begin
            state_n = PC_R;
            addr_n = addr - 1'b1;
          end
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_n = (state_n != IDLE) && (state_n != END);

  // Outputs are registered from the next-state view so strobes line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_phase <= 1'b0;
      ram_wr <= 1'b0;
      ram_rd <= 1'b0;
      ram_add <= '0;
      ram_din <= '0;
    end else begin
      busy <= busy_n;
      done <= (state_n == END);
      ram_wr <= (state_n == PA_W) || (state_n == PB_W);
      ram_rd <= (state_n == PB_R) || (state_n == PC_R);
      ram_add <= busy_n ? addr_n : '0;
      ram_din <= (state_n == PA_W) ? PATTERN :
                 (state_n == PB_W) ? ~PATTERN : '0;
      if (clr) begin
        pass <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_phase <= 1'b0;
      end else if (rec_pass) begin
        pass <= 1'b1;
      end else if (rec_fail) begin
        pass <= 1'b0;
        fail_addr <= addr;
        fail_data <= ram_dout;
        fail_phase <= rec_phase;
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural RAMs (RD_LAT 1 with stuck-at injection, RD_LAT 2),
// expected results queued at start and checked when done rises.
module tb_ram_march_bist;

  typedef struct {
    int cyc;
    logic pass;
    logic [9:0] fa;
    logic [7:0] fd;
    logic fp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic sel = 0;
  always #5 clk = ~clk;

  logic b1, d1, p1, fp1, wr1, rd1, b2, d2, p2, fp2, wr2, rd2;
  logic [9:0] fa1, add1, fa2, add2;
  logic [7:0] fd1, din1, dout1, fd2, din2, dout2;
  logic s1, s2;
  assign s1 = start & ~sel;
  assign s2 = start & sel;

  ram_march_bist u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .busy(b1), .done(d1), .pass(p1),
    .fail_addr(fa1), .fail_data(fd1), .fail_phase(fp1),
    .ram_wr(wr1), .ram_rd(rd1), .ram_add(add1), .ram_din(din1), .ram_dout(dout1)
  );

  ram_march_bist #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2), .busy(b2), .done(d2), .pass(p2),
    .fail_addr(fa2), .fail_data(fd2), .fail_phase(fp2),
    .ram_wr(wr2), .ram_rd(rd2), .ram_add(add2), .ram_din(din2), .ram_dout(dout2)
  );

  // RAM 1: one-cycle read, optional stuck-at-0 bits at one address
  logic [7:0] mem1 [1024];
  logic fault_on = 0;
  logic [9:0] f_addr = 0;
  logic [7:0] f_mask = 0;
  always @(posedge clk) begin
    if (wr1) mem1[add1] <= din1;
    if (rd1) dout1 <= (fault_on && add1 == f_addr) ? (mem1[add1] & ~f_mask) : mem1[add1];
  end

  // RAM 2: two-cycle read pipeline
  logic [7:0] mem2 [1024];
  logic [7:0] pipe2;
  always @(posedge clk) begin
    if (wr2) mem2[add2] <= din2;
    if (rd2) pipe2 <= mem2[add2];
    dout2 <= pipe2;
  end

  logic m_busy, m_done, m_pass, m_fp, m_wr, m_rd;
  logic [9:0] m_fa, m_add;
  logic [7:0] m_fd, m_din;
  assign m_busy = sel ? b2 : b1;
  assign m_done = sel ? d2 : d1;
  assign m_pass = sel ? p2 : p1;
  assign m_fp = sel ? fp2 : fp1;
  assign m_wr = sel ? wr2 : wr1;
  assign m_rd = sel ? rd2 : rd1;
  assign m_fa = sel ? fa2 : fa1;
  assign m_add = sel ? add2 : add1;
  assign m_fd = sel ? fd2 : fd1;
  assign m_din = sel ? din2 : din1;

  // Pulses start, then watches the selected DUT cycle by cycle (cycle 0 = first after start edge).
  task automatic run_dut(input int sp1, input int sp2, input int rst_cyc,
                         output int done_cyc, output int ovl, output int pa_err,
                         output int post, output int busy_err,
                         output logic c0_ok, output logic rst_ok);
    done_cyc = -1; ovl = 0; pa_err = 0; post = 0; busy_err = 0; c0_ok = 0; rst_ok = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (m_wr && m_rd) ovl++;
      if (cyc == 0)
        c0_ok = (m_done === 1'b0 && m_pass === 1'b0 && m_fa === 10'h0 &&
                 m_fd === 8'h0 && m_fp === 1'b0 && m_busy === 1'b1);
      if (cyc < 1024 && !(m_wr === 1'b1 && m_rd === 1'b0 && m_add === cyc[9:0] && m_din === 8'h55))
        pa_err++;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        rst_ok = ({m_busy, m_done, m_pass, m_fp, m_wr, m_rd, m_fa, m_add, m_fd, m_din} === '0);
        rst = 0;
        break;
      end
      if (m_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (m_busy !== 1'b1) busy_err++;
      start = (cyc == sp1 || cyc == sp2);
      if (rst_cyc >= 0 && cyc == rst_cyc) rst = 1;
    end
    start = 0;
    if (done_cyc >= 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_wr !== 1'b0 || m_rd !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b1) post++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({b1, d1, p1, fp1, wr1, rd1, fa1, add1, fd1, din1, b2, d2, p2, wr2, rd2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs dut1 busy=%b done=%b wr=%b rd=%b dut2 busy=%b done=%b, expected all 0",
               b1, d1, wr1, rd1, b2, d2);
    end
    rst = 0; start = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (b1 !== 1'b0 || d1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b, expected 0 0", b1, d1);
    end
  endtask

  task automatic test_fault_free(input string nm, input int sp1, input int sp2);
    exp_t e; int dc, ovl, pa, post, be; logic c0, rz;
    sel = 0; fault_on = 0;
    sb.push_back('{1024 * (4 + 2 * 1), 1'b1, 10'h0, 8'h0, 1'b0});
    run_dut(sp1, sp2, -1, dc, ovl, pa, post, be, c0, rz);
    e = sb.pop_front();
    checks++;
    if (dc !== e.cyc) begin failures++; $display("FAIL %s_done_cycle got %0d, expected %0d", nm, dc, e.cyc); end
    checks++;
    if ({m_pass, m_fa, m_fd, m_fp} !== {e.pass, e.fa, e.fd, e.fp}) begin
      failures++;
      $display("FAIL %s_result pass=%b addr=%h data=%h phase=%b, expected pass=%b addr=%h data=%h phase=%b",
               nm, m_pass, m_fa, m_fd, m_fp, e.pass, e.fa, e.fd, e.fp);
    end
    checks++;
    if (ovl !== 0 || pa !== 0 || be !== 0) begin
      failures++;
      $display("FAIL %s_strobes overlap=%0d phaseA_err=%0d busy_err=%0d, expected 0 0 0", nm, ovl, pa, be);
    end
    checks++;
    if (post !== 0 || c0 !== 1'b1) begin
      failures++;
      $display("FAIL %s_end_state post_err=%0d cycle0_clear=%b, expected 0 1", nm, post, c0);
    end
  endtask

  task automatic test_stuck(input string nm, input logic [9:0] a, input logic [7:0] mask,
                            input int exp_cyc, input logic [7:0] exp_d, input logic exp_ph);
    exp_t e; int dc, ovl, pa, post, be; logic c0, rz;
    sel = 0; fault_on = 1; f_addr = a; f_mask = mask;
    sb.push_back('{exp_cyc, 1'b0, a, exp_d, exp_ph});
    run_dut(-1, -1, -1, dc, ovl, pa, post, be, c0, rz);
    e = sb.pop_front();
    fault_on = 0;
    checks++;
    if (dc !== e.cyc) begin failures++; $display("FAIL %s_done_cycle got %0d, expected %0d", nm, dc, e.cyc); end
    checks++;
    if ({m_pass, m_fa, m_fd, m_fp} !== {e.pass, e.fa, e.fd, e.fp}) begin
      failures++;
      $display("FAIL %s_result pass=%b addr=%h data=%h phase=%b, expected pass=%b addr=%h data=%h phase=%b",
               nm, m_pass, m_fa, m_fd, m_fp, e.pass, e.fa, e.fd, e.fp);
    end
    checks++;
    if (post !== 0 || ovl !== 0 || pa !== 0) begin
      failures++;
      $display("FAIL %s_after_abort post_err=%0d overlap=%0d phaseA_err=%0d, expected 0 0 0", nm, post, ovl, pa);
    end
    checks++;
    if (c0 !== 1'b1) begin failures++; $display("FAIL %s_start_clears got %b, expected 1", nm, c0); end
  endtask

  task automatic test_reset_mid();
    int dc, ovl, pa, post, be; logic c0, rz;
    sel = 0; fault_on = 0;
    run_dut(-1, -1, 2000, dc, ovl, pa, post, be, c0, rz);
    checks++;
    if (rz !== 1'b1 || dc !== -1) begin
      failures++;
      $display("FAIL reset_mid_outputs zero=%b done_cycle=%0d, expected 1 -1", rz, dc);
    end
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold done=%b busy=%b, expected 0 0", m_done, m_busy);
    end
    test_fault_free("after_reset", -1, -1);
  endtask

  task automatic test_rd_lat2();
    exp_t e; int dc, ovl, pa, post, be; logic c0, rz;
    sel = 1;
    sb.push_back('{1024 * (4 + 2 * 2), 1'b1, 10'h0, 8'h0, 1'b0});
    run_dut(-1, -1, -1, dc, ovl, pa, post, be, c0, rz);
    e = sb.pop_front();
    checks++;
    if (dc !== e.cyc) begin failures++; $display("FAIL rdlat2_done_cycle got %0d, expected %0d", dc, e.cyc); end
    checks++;
    if ({m_pass, m_fa, m_fd, m_fp} !== {e.pass, e.fa, e.fd, e.fp}) begin
      failures++;
      $display("FAIL rdlat2_result pass=%b addr=%h data=%h, expected pass=%b addr=%h data=%h",
               m_pass, m_fa, m_fd, e.pass, e.fa, e.fd);
    end
    checks++;
    if (ovl !== 0 || pa !== 0 || be !== 0 || post !== 0) begin
      failures++;
      $display("FAIL rdlat2_strobes overlap=%0d phaseA_err=%0d busy_err=%0d post_err=%0d, expected 0",
               ovl, pa, be, post);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_fault_free("fault_free", -1, -1);
    test_fault_free("start_while_busy", 10, 3000);
    test_stuck("stuck_b", 10'h123, 8'h01, 1024 + 3 * 'h123 + 2, 8'h54, 1'b0);
    test_stuck("stuck_c", 10'h3FF, 8'h02, 4096 + 1 + 1, 8'hA8, 1'b1);
    test_reset_mid();
    test_rd_lat2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
